// File: rtl/uart_line_feeder_pkg.sv
// Shared definitions for the UART line feeder: FSM state encoding and the
// default byte that marks the end of a line.
package uart_line_feeder_pkg;

    localparam logic [7:0] LINE_CHAR = 8'h0A;

    typedef logic [2:0] feeder_state_e;

    localparam feeder_state_e ST_IDLE  = 3'd0;
    localparam feeder_state_e ST_FETCH = 3'd1;
    localparam feeder_state_e ST_LOAD  = 3'd2;
    localparam feeder_state_e ST_SEND  = 3'd3;
    localparam feeder_state_e ST_PAUSE = 3'd4;

endpackage

// File: rtl/uart_feeder_pause_timer.sv
// Post-line pause timer: waits pause_symbols UART symbol times, where one
// symbol lasts max(symbol_cycles, 1) clock cycles. Both counters are only
// ever loaded and decremented, so neither can overflow. expired_o is high
// during the final cycle of the pause so the FSM can leave on that edge.
module uart_feeder_pause_timer #(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic                clear_i,
    input  logic [CntWidth-1:0] symbol_cycles_i,
    input  logic [7:0]          pause_symbols_i,
    output logic                expired_o
);

    logic                active_q;
    logic [CntWidth-1:0] reload_q;
    logic [CntWidth-1:0] sym_cnt_q;
    logic [7:0]          pause_cnt_q;
    logic [CntWidth-1:0] reload_value;

    // A symbol period of zero behaves as a one-cycle symbol.
    assign reload_value = (symbol_cycles_i == '0) ? '0 : (symbol_cycles_i - CntWidth'(1));

    assign expired_o = active_q && (sym_cnt_q == '0) && (pause_cnt_q == 8'd1);

    // Count symbol cycles down and step the pause counter on every symbol wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q    <= 1'b0;
            reload_q    <= '0;
            sym_cnt_q   <= '0;
            pause_cnt_q <= 8'd0;
        end else if (clear_i) begin
            active_q    <= 1'b0;
            sym_cnt_q   <= '0;
            pause_cnt_q <= 8'd0;
        end else if (load_i) begin
            active_q    <= (pause_symbols_i != 8'd0);
            reload_q    <= reload_value;
            sym_cnt_q   <= reload_value;
            pause_cnt_q <= pause_symbols_i;
        end else if (active_q) begin
            if (sym_cnt_q == '0) begin
                sym_cnt_q   <= reload_q;
                pause_cnt_q <= pause_cnt_q - 8'd1;
                if (pause_cnt_q == 8'd1) begin
                    active_q <= 1'b0;
                end
            end else begin
                sym_cnt_q <= sym_cnt_q - CntWidth'(1);
            end
        end
    end

endmodule

// File: rtl/uart_line_feeder.sv
// Streams a byte image from a read-only buffer into a UART transmitter,
// one byte at a time (fetch, load, send; no prefetch), and inserts a
// programmable pause after every line terminator so a slow line-oriented
// shell on the far side can keep up.
module uart_line_feeder
    import uart_line_feeder_pkg::*;
#(
    parameter int         AddrWidth = 12,
    parameter int         CntWidth  = 16,
    parameter logic [7:0] LineChar  = LINE_CHAR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic [AddrWidth-1:0] len_i,
    input  logic [CntWidth-1:0]  symbol_cycles_i,
    input  logic [7:0]           pause_symbols_i,
    output logic                 mem_req_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    input  logic [7:0]           mem_rdata_i,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 aborted_o,
    output logic [AddrWidth-1:0] sent_cnt_o
);

    localparam logic [AddrWidth-1:0] ONE_ADDR = AddrWidth'(1);

    feeder_state_e        state_q;
    logic [AddrWidth-1:0] len_q;
    logic [CntWidth-1:0]  symbol_q;
    logic [7:0]           pause_q;
    logic [AddrWidth-1:0] addr_q;
    logic [AddrWidth-1:0] sent_cnt_q;
    logic [7:0]           data_q;
    logic                 done_q;
    logic                 aborted_q;

    logic handshake;
    logic line_hit;
    logic last_byte;
    logic pause_load;
    logic pause_expired;

    assign handshake  = (state_q == ST_SEND) && tx_ready_i;
    assign line_hit   = (data_q == LineChar) && (pause_q != 8'd0);
    assign last_byte  = ((sent_cnt_q + ONE_ADDR) == len_q);
    assign pause_load = handshake && line_hit && !abort_i;

    assign mem_req_o  = (state_q == ST_FETCH);
    assign mem_addr_o = addr_q;
    assign tx_valid_o = (state_q == ST_SEND);
    assign tx_data_o  = data_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign done_o     = done_q;
    assign aborted_o  = aborted_q;
    assign sent_cnt_o = sent_cnt_q;

    uart_feeder_pause_timer #(
        .CntWidth (CntWidth)
    ) u_pause_timer (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .load_i          (pause_load),
        .clear_i         (abort_i),
        .symbol_cycles_i (symbol_q),
        .pause_symbols_i (pause_q),
        .expired_o       (pause_expired)
    );

    // Main sequencer: config capture, byte fetch/send, pause and abort handling.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            symbol_q   <= '0;
            pause_q    <= 8'd0;
            addr_q     <= '0;
            sent_cnt_q <= '0;
            data_q     <= 8'd0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if ((state_q != ST_IDLE) && abort_i) begin
                state_q   <= ST_IDLE;
                aborted_q <= 1'b1;
                if (handshake) begin
                    sent_cnt_q <= sent_cnt_q + ONE_ADDR;
                    addr_q     <= addr_q + ONE_ADDR;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_i && !abort_i) begin
                            len_q      <= len_i;
                            symbol_q   <= symbol_cycles_i;
                            pause_q    <= pause_symbols_i;
                            addr_q     <= '0;
                            sent_cnt_q <= '0;
                            if (len_i == '0) begin
                                done_q <= 1'b1;
                            end else begin
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                    ST_FETCH: begin
                        state_q <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        data_q  <= mem_rdata_i;
                        state_q <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (tx_ready_i) begin
                            sent_cnt_q <= sent_cnt_q + ONE_ADDR;
                            addr_q     <= addr_q + ONE_ADDR;
                            if (line_hit) begin
                                state_q <= ST_PAUSE;
                            end else if (last_byte) begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                    ST_PAUSE: begin
                        if (pause_expired) begin
                            if (sent_cnt_q == len_q) begin
                                state_q <= ST_IDLE;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_FETCH;
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_line_feeder.sv
// Self-checking bench for uart_line_feeder: expected UART bytes are queued
// as each run is issued and a monitor compares them at every handshake.
module tb_uart_line_feeder;

    localparam int AW = 12;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] len = '0;
    logic [CW-1:0] sym = '0;
    logic [7:0]    pause = 8'd0;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_rdata = 8'd0;
    logic          tx_valid;
    logic [7:0]    tx_data;
    logic          tx_ready = 1'b1;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW-1:0] sent_cnt;

    logic [7:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int hs_total = 0;
    int req_cnt = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int last_done_cyc = 0;
    logic [7:0] exp_q[$];
    int hs_cyc[$];
    logic [7:0] exp_byte;

    uart_line_feeder #(
        .AddrWidth (AW),
        .CntWidth  (CW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .start_i         (start),
        .abort_i         (abort),
        .len_i           (len),
        .symbol_cycles_i (sym),
        .pause_symbols_i (pause),
        .mem_req_o       (mem_req),
        .mem_addr_o      (mem_addr),
        .mem_rdata_i     (mem_rdata),
        .tx_valid_o      (tx_valid),
        .tx_data_o       (tx_data),
        .tx_ready_i      (tx_ready),
        .busy_o          (busy),
        .done_o          (done),
        .aborted_o       (aborted),
        .sent_cnt_o      (sent_cnt)
    );

    // Free-running clock and cycle stamp.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Buffer model: data valid the cycle after a read strobe.
    always @(posedge clk) if (mem_req) mem_rdata <= mem[mem_addr];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops one expected byte per UART handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                hs_total++;
                hs_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL tx_unexpected: got %0h expected none", tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    check_output("tx_byte", 32'(tx_data), 32'(exp_byte));
                end
            end
            if (mem_req) req_cnt++;
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (aborted) abort_cnt++;
        end
    end

    task automatic apply_stimulus(input logic [AW-1:0] l, input logic [CW-1:0] s, input logic [7:0] p);
        @(posedge clk); #1;
        len = l;
        sym = s;
        pause = p;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < budget);
        check_output(name, 32'(done), 32'd1);
        #1;
    endtask

    // Watchdog so the run always ends.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int base_req, base_done, base_abort, base_hs, bad, n;
        for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h00;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_mem_req", 32'(mem_req), 0);
        check_output("rst_mem_addr", 32'(mem_addr), 0);
        check_output("rst_tx_valid", 32'(tx_valid), 0);
        check_output("rst_tx_data", 32'(tx_data), 0);
        check_output("rst_busy", 32'(busy), 0);
        check_output("rst_done", 32'(done), 0);
        check_output("rst_aborted", 32'(aborted), 0);
        check_output("rst_sent_cnt", 32'(sent_cnt), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // "ab\nc", symbol 10, pause 2
        $display("[TB] line with pause");
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h0A; mem[3] = 8'h63;
        exp_q.push_back(8'h61); exp_q.push_back(8'h62);
        exp_q.push_back(8'h0A); exp_q.push_back(8'h63);
        hs_cyc.delete();
        apply_stimulus(12'd4, 16'd10, 8'd2);
        @(negedge clk);
        check_output("t1_req_n1", 32'(mem_req), 1);
        check_output("t1_addr_n1", 32'(mem_addr), 0);
        @(negedge clk);
        @(negedge clk);
        check_output("t1_valid_n3", 32'(tx_valid), 1);
        check_output("t1_data_n3", 32'(tx_data), 32'h61);
        wait_done("t1_done", 200);
        check_output("t1_hs_count", 32'(hs_cyc.size()), 4);
        check_output("t1_gap_ready", 32'(hs_cyc[1] - hs_cyc[0]), 3);
        check_output("t1_gap_pause", 32'(hs_cyc[3] - hs_cyc[2]), 23);
        check_output("t1_done_lat", 32'(last_done_cyc - hs_cyc[3]), 1);
        check_output("t1_sent_cnt", 32'(sent_cnt), 4);
        check_output("t1_busy_fall", 32'(busy), 0);
        check_output("t1_sb_empty", 32'(exp_q.size()), 0);

        // Backpressure: ready low for 7 cycles in SEND
        $display("[TB] backpressure");
        mem[0] = 8'h41; mem[1] = 8'h42;
        exp_q.push_back(8'h41); exp_q.push_back(8'h42);
        tx_ready = 1'b0;
        base_req = req_cnt;
        apply_stimulus(12'd2, 16'd3, 8'd0);
        repeat (3) @(negedge clk);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'h41) bad++;
            if (i < 6) @(negedge clk);
        end
        check_output("t2_stall_stable", 32'(bad), 0);
        @(posedge clk); #1;
        tx_ready = 1'b1;
        wait_done("t2_done", 100);
        check_output("t2_req_count", 32'(req_cnt - base_req), 2);
        check_output("t2_sent_cnt", 32'(sent_cnt), 2);
        check_output("t2_sb_empty", 32'(exp_q.size()), 0);

        // Zero-length start
        $display("[TB] zero length");
        base_req = req_cnt;
        base_done = done_cnt;
        apply_stimulus(12'd0, 16'd5, 8'd1);
        @(negedge clk);
        check_output("t3_done", 32'(done), 1);
        check_output("t3_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        #1;
        check_output("t3_no_req", 32'(req_cnt - base_req), 0);
        check_output("t3_one_done", 32'(done_cnt - base_done), 1);
        check_output("t3_sent_cnt", 32'(sent_cnt), 0);

        // Abort in the middle of a pause, then rerun from address 0
        $display("[TB] abort in pause");
        mem[0] = 8'h78; mem[1] = 8'h0A; mem[2] = 8'h79;
        exp_q.push_back(8'h78); exp_q.push_back(8'h0A);
        base_hs = hs_total;
        base_done = done_cnt;
        base_abort = abort_cnt;
        apply_stimulus(12'd3, 16'd4, 8'd5);
        n = 0;
        while ((hs_total - base_hs) < 2 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check_output("t4_reach_pause", 32'(hs_total - base_hs), 2);
        repeat (5) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check_output("t4_aborted", 32'(aborted), 1);
        check_output("t4_no_done", 32'(done), 0);
        check_output("t4_idle", 32'(busy), 0);
        check_output("t4_valid_low", 32'(tx_valid), 0);
        check_output("t4_sent_kept", 32'(sent_cnt), 2);
        repeat (25) @(negedge clk);
        #1;
        check_output("t4_done_count", 32'(done_cnt - base_done), 0);
        check_output("t4_abort_count", 32'(abort_cnt - base_abort), 1);
        mem[0] = 8'h5A;
        exp_q.push_back(8'h5A);
        apply_stimulus(12'd1, 16'd2, 8'd0);
        @(negedge clk);
        check_output("t4_rerun_req", 32'(mem_req), 1);
        check_output("t4_rerun_addr", 32'(mem_addr), 0);
        wait_done("t4_rerun_done", 100);
        check_output("t4_rerun_sent", 32'(sent_cnt), 1);
        check_output("t4_sb_empty", 32'(exp_q.size()), 0);

        // symbol_cycles 0 behaves as 1: trailing LineChar pauses 3 cycles
        $display("[TB] zero symbol period");
        mem[0] = 8'h0A;
        exp_q.push_back(8'h0A);
        hs_cyc.delete();
        apply_stimulus(12'd1, 16'd0, 8'd3);
        wait_done("t5_done", 100);
        check_output("t5_hs_count", 32'(hs_cyc.size()), 1);
        check_output("t5_done_lat", 32'(last_done_cyc - hs_cyc[0]), 4);
        check_output("t5_sent_cnt", 32'(sent_cnt), 1);

        // Simultaneous start and abort in IDLE
        $display("[TB] start with abort");
        base_req = req_cnt;
        base_done = done_cnt;
        base_abort = abort_cnt;
        @(posedge clk); #1;
        len = 12'd3;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check_output("t6_no_busy", 32'(busy), 0);
        repeat (4) @(negedge clk);
        #1;
        check_output("t6_no_req", 32'(req_cnt - base_req), 0);
        check_output("t6_no_done", 32'(done_cnt - base_done), 0);
        check_output("t6_no_abort", 32'(abort_cnt - base_abort), 0);

        // Start while busy is ignored, mid-run length change has no effect
        $display("[TB] start while busy");
        mem[0] = 8'h50; mem[1] = 8'h51;
        exp_q.push_back(8'h50); exp_q.push_back(8'h51);
        apply_stimulus(12'd2, 16'd1, 8'd0);
        @(posedge clk); #1;
        len = 12'd1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("t7_done", 100);
        check_output("t7_sent_cnt", 32'(sent_cnt), 2);
        check_output("t7_sb_empty", 32'(exp_q.size()), 0);
        repeat (3) @(negedge clk);
        #1;
        check_output("t7_idle", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
